// File: rtl/present_key_sequencer_pkg.sv
// Shared widths, FSM encoding and the PRESENT 4-bit S-box for the round-key sequencer.
package present_pkg;
  localparam int KEY_W    = 80;
  localparam int RK_W     = 64;
  localparam int RK_IDX_W = 6;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_e;

  function automatic logic [3:0] present_sbox(input logic [3:0] v);
    logic [3:0] s;
    case (v)
      4'h0: s = 4'hC;  4'h1: s = 4'h5;  4'h2: s = 4'h6;  4'h3: s = 4'hB;
      4'h4: s = 4'h9;  4'h5: s = 4'h0;  4'h6: s = 4'hA;  4'h7: s = 4'hD;
      4'h8: s = 4'h3;  4'h9: s = 4'hE;  4'hA: s = 4'hF;  4'hB: s = 4'h8;
      4'hC: s = 4'h4;  4'hD: s = 4'h7;  4'hE: s = 4'h1;  default: s = 4'h2;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/present_key_sequencer_key_schedule.sv
// One PRESENT-80 key-register update: rotate left 61, S-box top nibble, XOR round counter.
module key_schedule
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] x,
  input  logic [4:0]       i,
  output logic [KEY_W-1:0] y
);
  logic [KEY_W-1:0] rot;

  // rotate left by 61 == rotate right by 19
  assign rot = {x[18:0], x[79:19]};
  assign y   = {present_sbox(rot[79:76]), rot[75:20], rot[19:15] ^ i, rot[14:0]};
endmodule

// File: rtl/present_key_sequencer.sv
// Sequential PRESENT-80 round-key generator: loads a key, emits K1..NUM_RK over a valid/ready handshake.
module present_key_sequencer
  import present_pkg::*;
#(
  parameter int NUM_RK = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_W-1:0]    key,
  input  logic                abort,
  output logic                busy,
  output logic [RK_W-1:0]     rk,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                done
);
  state_e              state_q, state_d;
  logic [KEY_W-1:0]    key_q, key_d, ks_out;
  logic [RK_IDX_W-1:0] ctr_q, ctr_d;
  logic                done_q, done_d;

  key_schedule u_ks (
    .x (key_q),
    .i (ctr_q[4:0]),
    .y (ks_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          ctr_d   = RK_IDX_W'(1);
          state_d = EMIT;
        end
      end
      EMIT: begin
        // abort wins over a same-cycle handshake
        if (abort) begin
          state_d = IDLE;
        end else if (rk_ready) begin
          if (ctr_q < RK_IDX_W'(NUM_RK)) begin
            key_d = ks_out;
            ctr_d = ctr_q + RK_IDX_W'(1);
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk       = key_q[79:16];
  assign rk_idx   = ctr_q;
  assign done     = done_q;
endmodule

// File: tb/tb_present_key_sequencer.sv
// Self-checking bench for present_key_sequencer against a software PRESENT-80 key expansion.
module tb_present_key_sequencer;
  localparam int NUM_RK = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [79:0] key = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic [63:0] rk;
  logic [5:0]  rk_idx;
  logic        rk_valid;
  logic        rk_ready = 1'b0;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [3:0]  sb [16];
  logic [63:0] exp_rk [1:NUM_RK];
  logic [63:0] got_rk [1:NUM_RK];

  typedef struct {
    logic [79:0] key;
    int          idx;
    logic [63:0] rk;
  } vec_t;
  vec_t vecs [5];

  present_key_sequencer #(.NUM_RK(NUM_RK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .abort(abort),
    .busy(busy), .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference expansion computed straight from the PRESENT-80 key-schedule rules.
  task automatic build_model(input logic [79:0] k0);
    logic [79:0] k;
    k = k0;
    for (int r = 1; r <= NUM_RK; r++) begin
      exp_rk[r] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = sb[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
  endtask

  // Called at a negedge with K1 expected on the bus; ends in the done cycle (or after abort).
  task automatic collect(input logic [79:0] k, input int mode, input int stall_idx,
                         input int stall_n, input bit start_mid, input int abort_at);
    int n, cyc, stall;
    bit held, r;
    logic [63:0] prev_rk;
    logic [5:0]  prev_idx;
    n = 1; cyc = 0; stall = 0; held = 0; prev_rk = '0; prev_idx = '0;
    build_model(k);
    while (n <= NUM_RK && cyc < 500) begin
      chk("rk_valid", 64'(rk_valid), 64'd1);
      if (held) begin
        chk("hold_rk", rk, prev_rk);
        chk("hold_idx", 64'(rk_idx), 64'(prev_idx));
      end
      chk("rk_idx", 64'(rk_idx), 64'(n));
      chk($sformatf("rk[%0d]", n), rk, exp_rk[n]);
      got_rk[n] = rk;
      r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (n == stall_idx && stall < stall_n) begin
        r = 1'b0;
        stall++;
      end
      start = start_mid && (n == 5);
      if (start_mid && n == 5) key = '1;
      if (n == abort_at) begin
        abort = 1'b1;
        r = 1'b1;
      end
      rk_ready = r;
      held = !r; prev_rk = rk; prev_idx = rk_idx;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        rk_ready = 1'b0;
        chk("abort_valid", 64'(rk_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("abort_no_done", 64'(done), 64'd0);
        return;
      end
      if (r) n++;
    end
    rk_ready = 1'b0;
    chk("budget", 64'(n > NUM_RK), 64'd1);
    if (mode == 0 && stall_n == 0) chk("consecutive", 64'(cyc), 64'(NUM_RK));
    chk("done", 64'(done), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_valid", 64'(rk_valid), 64'd0);
  endtask

  task automatic launch(input logic [79:0] k);
    key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_full(input logic [79:0] k, input int mode);
    launch(k);
    collect(k, mode, 0, 0, 0, 0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [79:0] rk_key;
    sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    vecs[0] = '{80'h0, 1, 64'h0000_0000_0000_0000};
    vecs[1] = '{80'h0, 2, 64'hC000_0000_0000_0000};
    vecs[2] = '{80'h0, 3, 64'h5000_1800_0000_0001};
    vecs[3] = '{'1,    1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{80'h0123_4567_89AB_CDEF_0011, 1, 64'h0123_4567_89AB_CDEF};

    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rk_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rk", rk, 64'd0);
    chk("rst_idx", 64'(rk_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // table vectors: known round keys
    for (int v = 0; v < 5; v++) begin
      run_full(vecs[v].key, 0);
      chk($sformatf("vec%0d", v), got_rk[vecs[v].idx], vecs[v].rk);
    end

    // backpressure at idx 2 for 5 cycles
    launch('0);
    collect('0, 0, 2, 5, 0, 0);
    @(negedge clk);

    // start during EMIT must be ignored
    launch('0);
    collect('0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("no_restart", 64'(busy), 64'd0);

    // abort at idx 10, then fresh start with all-ones key
    launch('0);
    collect('0, 0, 0, 0, 0, 10);
    launch('1);
    chk("after_abort_k1", rk, 64'hFFFF_FFFF_FFFF_FFFF);
    collect('1, 0, 0, 0, 0, 0);

    // back-to-back: start in the done cycle, random keys and random ready
    for (int t = 0; t < 6; t++) begin
      rk_key[79:48] = $urandom();
      rk_key[47:16] = $urandom();
      rk_key[15:0]  = 16'($urandom());
      launch(rk_key);
      collect(rk_key, 1, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk("b2b_done_pulse", 64'(done), 64'd0);

    // asynchronous reset mid-run
    launch('0);
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_valid", 64'(rk_valid), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_rk", rk, 64'd0);
    rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle", 64'(busy), 64'd0);
    chk("mrst_no_done", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
